// File: rtl/riot_pia.sv
// RIOT (6532) I/O ports, data-direction registers and interval timer; no RAM. Optional DDR/output registers via RIOT_DDR_EN.
// Latency: reads are combinational from adr_i; writes, timer loads and INTIM-read flag clear act on the access edge.
// Backpressure: none; one register access per CPU-rate clock is always accepted.
module riot_pia (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [6:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    input  logic [6:0] buttons,
    input  logic [3:0] sw
);

    // Timer state: count, prescaler, selected interval, underflow flag, post-underflow fast mode
    logic [7:0] timer;
    logic [9:0] presc;
    logic [1:0] intvl_sel;
    logic       flag;
    logic       fast;

    // Address decode; adr_i[6:5] and adr_i[3] are don't-care so the block mirrors across them
    logic       wr_acc;
    logic       rd_intim;
    logic       tim_load;
    logic       io_wr;
    logic [7:0] port_a_in;
    logic [7:0] port_b_in;
    logic       unused;

    assign wr_acc   = stb_i & we_i;
    assign rd_intim = stb_i & ~we_i & adr_i[2] & ~adr_i[0];
    assign tim_load = wr_acc & adr_i[2] & adr_i[4];
    assign io_wr    = wr_acc & ~adr_i[2];

    // Joystick directions and console switches as the CPU sees them (active-low where wired that way)
    assign port_a_in = {~buttons[4], ~buttons[3], ~buttons[2], ~buttons[1], 4'hF};
    assign port_b_in = {1'b0, ~sw[3], 2'b11, sw[2], 1'b1, ~sw[1], ~sw[0]};
    assign unused    = ^{adr_i[6:5], adr_i[3], buttons[6:5], buttons[0]};

    // Prescaler reload value (interval - 1) for TIM1T/TIM8T/TIM64T/T1024T
    function automatic logic [9:0] reload(input logic [1:0] sel);
        case (sel)
            2'd0:    reload = 10'd0;
            2'd1:    reload = 10'd7;
            2'd2:    reload = 10'd63;
            default: reload = 10'd1023;
        endcase
    endfunction

    // Interval timer: load wins; otherwise prescaled countdown, underflow to 0xFF then free-run every edge
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= 8'h00;
            presc     <= 10'd1023;
            intvl_sel <= 2'd3;
            flag      <= 1'b0;
            fast      <= 1'b0;
        end else if (tim_load) begin
            timer     <= dat_i;
            intvl_sel <= adr_i[1:0];
            presc     <= reload(adr_i[1:0]);
            flag      <= 1'b0;
            fast      <= 1'b0;
        end else begin
            if (rd_intim) begin
                flag <= 1'b0;
            end
            if (fast) begin
                timer <= timer - 8'd1;
            end else if (presc == 10'd0) begin
                presc <= reload(intvl_sel);
                if (timer == 8'h00) begin
                    // underflow set takes priority over a same-edge INTIM read clear
                    timer <= 8'hFF;
                    flag  <= 1'b1;
                    fast  <= 1'b1;
                end else begin
                    timer <= timer - 8'd1;
                end
            end else begin
                presc <= presc - 10'd1;
            end
        end
    end

`ifdef RIOT_DDR_EN
    logic [7:0] ddr_a;
    logic [7:0] out_a;
    logic [7:0] ddr_b;
    logic [7:0] out_b;

    // Port output latches and data-direction registers, written through the I/O register window
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ddr_a <= 8'h00;
            out_a <= 8'h00;
            ddr_b <= 8'h00;
            out_b <= 8'h00;
        end else if (io_wr) begin
            case (adr_i[1:0])
                2'd0:    out_a <= dat_i;
                2'd1:    ddr_a <= dat_i;
                2'd2:    out_b <= dat_i;
                default: ddr_b <= dat_i;
            endcase
        end
    end

    // Read mux: output bits come from the latch, input bits from the pins
    always_comb begin
        dat_o = 8'h00;
        if (adr_i[2]) begin
            dat_o = adr_i[0] ? {flag, 7'b0} : timer;
        end else begin
            case (adr_i[1:0])
                2'd0:    dat_o = (ddr_a & out_a) | (~ddr_a & port_a_in);
                2'd1:    dat_o = ddr_a;
                2'd2:    dat_o = (ddr_b & out_b) | (~ddr_b & port_b_in);
                default: dat_o = ddr_b;
            endcase
        end
    end
`else
    logic unused_io_wr;
    assign unused_io_wr = io_wr;

    // Read mux: ports are input-only, direction registers read as zero
    always_comb begin
        dat_o = 8'h00;
        if (adr_i[2]) begin
            dat_o = adr_i[0] ? {flag, 7'b0} : timer;
        end else begin
            case (adr_i[1:0])
                2'd0:    dat_o = port_a_in;
                2'd2:    dat_o = port_b_in;
                default: dat_o = 8'h00;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_riot_pia.sv
// Self-checking bench for riot_pia: directed steps plus randomized accesses checked against a cycle-arithmetic model.
// Latency: outputs sampled 1..n time units after each rising edge, well before the next one.
// Backpressure: not applicable.
module tb_riot_pia;

    logic       clk_i = 1'b0;
    logic       rst_n;
    logic       stb_i;
    logic       we_i;
    logic [6:0] adr_i;
    logic [7:0] dat_i;
    logic [7:0] dat_o;
    logic [6:0] buttons;
    logic [3:0] sw;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    // Reference model: timer as a function of edges elapsed since the last load
    int cur;
    int ld_edge;
    int ld_n;
    int ld_i;
    int last_rd;
    logic [7:0] m_ddra, m_ora, m_ddrb, m_orb;
    int ivals [4] = '{1, 8, 64, 1024};

    riot_pia dut (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .buttons(buttons),
        .sw     (sw)
    );

    always #10 clk_i = ~clk_i;

    function automatic logic [7:0] m_timer();
        int k;
        int span;
        k    = cur - ld_edge;
        span = (ld_n + 1) * ld_i;
        if (k < span) return 8'(ld_n - k / ld_i);
        return 8'(255 - ((k - span) % 256));
    endfunction

    function automatic logic m_flag();
        int uf;
        uf = ld_edge + (ld_n + 1) * ld_i;
        return (cur >= uf) && !(last_rd > uf);
    endfunction

    function automatic logic [7:0] m_rd(input logic [6:0] a);
        logic [7:0] pa;
        logic [7:0] pb;
        pa = {~buttons[4], ~buttons[3], ~buttons[2], ~buttons[1], 4'hF};
        pb = {1'b0, ~sw[3], 2'b11, sw[2], 1'b1, ~sw[1], ~sw[0]};
        if (a[2]) return a[0] ? {m_flag(), 7'b0} : m_timer();
`ifdef RIOT_DDR_EN
        case (a[1:0])
            2'd0:    return (m_ddra & m_ora) | (~m_ddra & pa);
            2'd1:    return m_ddra;
            2'd2:    return (m_ddrb & m_orb) | (~m_ddrb & pb);
            default: return m_ddrb;
        endcase
`else
        case (a[1:0])
            2'd0:    return pa;
            2'd2:    return pb;
            default: return 8'h00;
        endcase
`endif
    endfunction

    task automatic model_reset();
        cur     = 0;
        ld_edge = 0;
        ld_n    = 0;
        ld_i    = 1024;
        last_rd = -1;
        m_ddra  = 8'h00;
        m_ora   = 8'h00;
        m_ddrb  = 8'h00;
        m_orb   = 8'h00;
    endtask

    // Apply the access currently on the bus to the model, then clock it into the DUT
    task automatic step();
        int e;
        e = cur + 1;
        if (stb_i && we_i) begin
            if (adr_i[2]) begin
                if (adr_i[4]) begin
                    ld_edge = e;
                    ld_n    = int'(dat_i);
                    ld_i    = ivals[adr_i[1:0]];
                    last_rd = -1;
                end
            end else begin
                case (adr_i[1:0])
                    2'd0:    m_ora  = dat_i;
                    2'd1:    m_ddra = dat_i;
                    2'd2:    m_orb  = dat_i;
                    default: m_ddrb = dat_i;
                endcase
            end
        end else if (stb_i && !we_i && adr_i[2] && !adr_i[0]) begin
            last_rd = e;
        end
        cur = e;
        @(posedge clk_i);
        #1;
        stb_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [6:0] a, output logic [7:0] v);
        adr_i = a;
        #1;
        v = dat_o;
    endtask

    // Peek an address without a bus access and compare against the model
    task automatic peek_chk(input string tag, input logic [6:0] a);
        logic [7:0] v;
        peek(a, v);
        chk(tag, v, m_rd(a));
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        stb_i = 1'b1;
        we_i  = 1'b1;
        adr_i = a;
        dat_i = d;
        step();
    endtask

    task automatic rd(input logic [6:0] a);
        stb_i = 1'b1;
        we_i  = 1'b0;
        adr_i = a;
        step();
    endtask

    initial begin
        logic [7:0] v;
        logic [6:0] a;
        int op;

        rst_n   = 1'b0;
        stb_i   = 1'b0;
        we_i    = 1'b0;
        adr_i   = 7'h00;
        dat_i   = 8'h00;
        buttons = 7'b0010010;
        sw      = 4'b0101;
        model_reset();
        #15;
        rst_n = 1'b1;

        // Reset state and port input mapping
        peek(7'h00, v); chk("rst_swcha", v, 8'h6F);
        peek(7'h02, v); chk("rst_swchb", v, 8'h7E);
        peek(7'h04, v); chk("rst_intim", v, 8'h00);
        peek(7'h05, v); chk("rst_timint", v, 8'h00);
        peek(7'h01, v); chk("rst_swacnt", v, 8'h00);
        peek(7'h03, v); chk("rst_swbcnt", v, 8'h00);

        // TIM64T = 3: countdown, underflow at 4*64 edges, then fast mode
        wr(7'h16, 8'h03);
        for (int c = 1; c <= 260; c++) begin
            peek(7'h04, v);
            chk("t64_intim", v, m_rd(7'h04));
            if (c == 64)  chk("t64_c64", v, 8'h03);
            if (c == 65)  chk("t64_c65", v, 8'h02);
            if (c == 193) chk("t64_c193", v, 8'h00);
            if (c == 257) begin
                chk("t64_uf", v, 8'hFF);
                peek(7'h05, v);
                chk("t64_flag", v, 8'h80);
            end
            if (c == 258) chk("t64_fast", v, 8'hFE);
            step();
        end

        // One INTIM read clears the flag; timer keeps running at one per edge
        rd(7'h04);
        peek(7'h05, v); chk("rdclr_flag", v, 8'h00);
        for (int c = 0; c < 4; c++) begin
            peek_chk("rdclr_intim", 7'h04);
            peek_chk("rdclr_timint", 7'h05);
            step();
        end

        // TIM1T = 0 underflows on the first edge; T1024T load then clears flag and fast mode
        wr(7'h14, 8'h00);
        peek(7'h04, v); chk("t1_load", v, 8'h00);
        step();
        peek(7'h04, v); chk("t1_uf", v, 8'hFF);
        peek(7'h05, v); chk("t1_flag", v, 8'h80);
        wr(7'h17, 8'h05);
        peek(7'h05, v); chk("t1024_flag", v, 8'h00);
        for (int c = 1; c <= 1025; c++) begin
            peek(7'h04, v);
            chk("t1024_intim", v, m_rd(7'h04));
            if (c == 1024) chk("t1024_hold", v, 8'h05);
            if (c == 1025) chk("t1024_dec", v, 8'h04);
            step();
        end

        // Data-direction registers and output latches
        buttons = 7'b0000000;
        wr(7'h01, 8'hF0);
        wr(7'h00, 8'hA0);
`ifdef RIOT_DDR_EN
        peek(7'h00, v); chk("ddr_swcha", v, 8'hAF);
        peek(7'h01, v); chk("ddr_swacnt", v, 8'hF0);
`else
        peek(7'h00, v); chk("ddr_swcha", v, 8'hFF);
        peek(7'h01, v); chk("ddr_swacnt", v, 8'h00);
`endif
        wr(7'h0B, 8'h0F);
        wr(7'h6A, 8'h05);
        peek_chk("ddr_swchb", 7'h02);
        peek_chk("ddr_swbcnt", 7'h03);

        // Randomized accesses, mirrored addresses and port inputs against the model
        for (int c = 0; c < 600; c++) begin
            buttons = 7'($urandom);
            sw      = 4'($urandom);
            peek_chk("rnd_peek", 7'($urandom));
            peek_chk("rnd_intim", 7'h04);
            peek_chk("rnd_timint", 7'h05);
            op = $urandom_range(0, 9);
            a  = 7'($urandom);
            if (op == 0) begin
                a[2] = 1'b1;
                a[4] = 1'b1;
                a[1:0] = 2'($urandom_range(0, 2));
                wr(a, 8'($urandom_range(0, 3)));
            end else if (op <= 2) begin
                a[2] = 1'b0;
                wr(a, 8'($urandom));
            end else if (op == 3) begin
                a[2] = 1'b1;
                a[4] = 1'b0;
                wr(a, 8'($urandom));
            end else if (op <= 6) begin
                rd(a);
            end else begin
                step();
            end
        end

        // Asynchronous reset mid-count takes effect without a clock edge
        wr(7'h01, 8'h3C);
        wr(7'h03, 8'hC3);
        wr(7'h15, 8'h40);
        step();
        step();
        #3;
        rst_n = 1'b0;
        model_reset();
        peek(7'h04, v); chk("arst_intim", v, 8'h00);
        peek(7'h05, v); chk("arst_timint", v, 8'h00);
        peek(7'h01, v); chk("arst_swacnt", v, 8'h00);
        peek(7'h03, v); chk("arst_swbcnt", v, 8'h00);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            peek_chk("post_rst_intim", 7'h04);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
